spi_send_sequencer: RTL and testbench
=====================================

Name: spi_send_sequencer

Overview:
- Upstream feeder for the 4-pin SPI master's send interface.
- Buffers words written by the system side in a small FIFO and launches one SPI frame per word using the master's toggle handshake (Sync toggle out, Over_ack toggle back).
- Enforces a minimum inter-frame gap so SS can return high between frames.
- Detects a master that never acknowledges.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, 2..64.
- TIMEOUT_CYCLES, 4096, c_clk_100m cycles to wait for the ack toggle before declaring timeout; must be >= 8.
- GAP_CYCLES, 8, idle c_clk_100m cycles after each frame before the next launch; must be >= 4, which covers 2 slow-clock periods for the master's SS-high idle.

Ports:
- c_clk_100m  in  1  system clock; the only clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr_valid  in  1  write request.
- o_wr_ready  out  1  high when the FIFO is not full.
- i_wr_data  in  32  word to send.
- o_SPI_Send_Sync  out  1  toggles once per launched frame.
- o_SPI_Send_Data  out  32  word for the master; held stable while a frame is outstanding.
- i_SPI_Send_Over_ack  in  1  master completion toggle; produced by the divided-clock logic.
- i_clr_err  in  1  single-cycle pulse; clears the error state.
- o_busy  out  1  high when the FSM is not IDLE or the FIFO is not empty.
- o_fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- o_timeout_pulse  out  1  one-cycle pulse on timeout.
- o_err  out  1  sticky error flag.
- o_frame_count  out  16  completed-frame counter (optional feature).

Behaviour:
- Reset: asynchronous on i_rst_n low. All outputs 0 except o_wr_ready=1. FIFO empty, FSM IDLE, r_ack_exp=0, sync flops 0.
- Write handshake: a write occurs when i_wr_valid && o_wr_ready. A write while full is ignored; ready is low, so it does not happen on a compliant bus.
- FIFO reads: the FIFO is read only at the IDLE->LAUNCH transition.
- Simultaneous read and write when full: not possible, because ready is low when full.
- Simultaneous read and write when empty: the written word is not readable until the next cycle.
- o_fifo_level: updated in the same cycle as the push/pop.
- Ack synchronizer: i_SPI_Send_Over_ack passes through a 2-flop synchronizer, giving ack_s.
- Completion condition: ack_s == r_ack_exp.
- FSM IDLE: if FIFO not empty and !o_err, pop the word into o_SPI_Send_Data, then go to LAUNCH.
- FSM LAUNCH (1 cycle):
  - toggle o_SPI_Send_Sync;
  - toggle r_ack_exp;
  - clear the timeout counter;
  - go to WAIT_ACK.
- FSM WAIT_ACK: the timeout counter increments every cycle.
  - If ack_s == r_ack_exp: increment frame count and go to GAP.
  - Else if the counter reaches TIMEOUT_CYCLES-1: pulse o_timeout_pulse, set o_err, go to ERROR.
  - If completion and timeout occur in the same cycle, completion wins.
- FSM GAP: count GAP_CYCLES, then go to IDLE.
- FSM ERROR:
  - No launches; the FIFO still accepts writes until full.
  - On i_clr_err: set r_ack_exp <= ack_s, clear o_err, go to GAP.
  - Re-syncing r_ack_exp makes a late ack from the abandoned frame harmless.
  - The abandoned word is dropped, not retried.
- Data hold rule: o_SPI_Send_Data changes only at the IDLE->LAUNCH pop. The master samples it in its SS state, one to two slow-clock periods after the Sync toggle.
- Sync rule: o_SPI_Send_Sync never toggles twice within one frame. At most one frame is outstanding.
- i_clr_err outside ERROR: ignored.
- Latency: a word written into an empty FIFO with the FSM in IDLE gives a Sync toggle 3 cycles after the write (write, IDLE pop, LAUNCH).
- Pointers: binary with one extra wrap bit; full = MSBs differ and the lower bits are equal.

Optional Feature:
- Macro: SPI_SEQ_STATS_EN.
- Defined:
  - o_frame_count increments on every completion and wraps 0xFFFF->0;
  - a timeout does not increment it;
  - it is cleared only by reset.
- Undefined: o_frame_count is tied to 0 and no counter logic is built.

Test Plan:
- Single word: reset, write 0xA5C3F1, master model acks after 60 cycles -> Sync toggles 0->1 at write+3, data stable through ack, o_busy falls GAP_CYCLES+1 cycles after ack_s matches, frame_count=1.
- Back-to-back fill: write 8 words with the master stalled -> o_wr_ready low after the 8th word; the 9th write is ignored, o_fifo_level=8, then words drain in order. Check the sent sequence equals the written sequence, with each pair of Sync toggles separated by >= GAP_CYCLES.
- Timeout: master never acks -> o_timeout_pulse exactly once at LAUNCH+TIMEOUT_CYCLES, o_err=1, no further toggles. The model then acks late, then i_clr_err -> next queued word launches with no spurious completion.
- Completion on the timeout cycle: ack_s matches on counter=TIMEOUT_CYCLES-1 -> no timeout pulse, normal GAP.
- Reset mid-frame: assert i_rst_n low during WAIT_ACK -> all outputs return immediately to reset values, FIFO empty, first frame after reset uses Sync 0->1.
- Write while popping (FIFO level 1 in IDLE): simultaneous write and pop -> level stays 1 and the new word is sent next.

Source files
------------

// File: rtl/spi_send_sequencer.sv
// spi_send_sequencer: FIFO-buffered launcher for the SPI master's toggle-handshake send port.
// Optional completed-frame counter is built when SPI_SEQ_STATS_EN is defined.
module spi_send_sequencer #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 8
) (
  input  logic                   c_clk_100m,
  input  logic                   i_rst_n,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [31:0]            i_wr_data,
  output logic                   o_SPI_Send_Sync,
  output logic [31:0]            o_SPI_Send_Data,
  input  logic                   i_SPI_Send_Over_ack,
  input  logic                   i_clr_err,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_fifo_level,
  output logic                   o_timeout_pulse,
  output logic                   o_err,
  output logic [15:0]            o_frame_count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GCW = $clog2(GAP_CYCLES);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_ERROR    = 3'd4;

  localparam logic [AW:0]    PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [TCW-1:0] TCNT_ONE = {{(TCW-1){1'b0}}, 1'b1};
  localparam logic [GCW-1:0] GCNT_ONE = {{(GCW-1){1'b0}}, 1'b1};
  localparam logic [TCW-1:0] TCNT_END = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [GCW-1:0] GCNT_END = GCW'(GAP_CYCLES - 1);

  logic [31:0]    mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [2:0]     state;
  logic           ack_meta;
  logic           ack_s;
  logic           r_ack_exp;
  logic [TCW-1:0] tcnt;
  logic [GCW-1:0] gcnt;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic ack_done;
  logic tmo_hit;
  logic gap_done;

  // Extra wrap bit on the pointers distinguishes full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = i_wr_valid && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty && !o_err;
  assign ack_done   = (ack_s == r_ack_exp);
  assign tmo_hit    = (tcnt == TCNT_END);
  assign gap_done   = (gcnt == GCNT_END);

  assign o_wr_ready   = !fifo_full;
  assign o_fifo_level = wr_ptr - rd_ptr;
  assign o_busy       = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge c_clk_100m) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= i_SPI_Send_Over_ack;
      ack_s    <= ack_meta;
    end
  end

  always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      rd_ptr          <= '0;
      o_SPI_Send_Data <= '0;
      o_SPI_Send_Sync <= 1'b0;
      r_ack_exp       <= 1'b0;
      tcnt            <= '0;
      gcnt            <= '0;
      o_timeout_pulse <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_timeout_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            o_SPI_Send_Data <= mem[rd_ptr[AW-1:0]];
            rd_ptr          <= rd_ptr + PTR_ONE;
            state           <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          o_SPI_Send_Sync <= ~o_SPI_Send_Sync;
          r_ack_exp       <= ~r_ack_exp;
          tcnt            <= '0;
          state           <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          tcnt <= tcnt + TCNT_ONE;
          // Completion is tested first so it wins over a same-cycle timeout.
          if (ack_done) begin
            gcnt  <= '0;
            state <= S_GAP;
          end else if (tmo_hit) begin
            o_timeout_pulse <= 1'b1;
            o_err           <= 1'b1;
            state           <= S_ERROR;
          end
        end
        S_GAP: begin
          if (gap_done) begin
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt + GCNT_ONE;
          end
        end
        S_ERROR: begin
          // Re-syncing the expected ack level makes a late ack from the dropped frame harmless.
          if (i_clr_err) begin
            r_ack_exp <= ack_s;
            o_err     <= 1'b0;
            gcnt      <= '0;
            state     <= S_GAP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_SEQ_STATS_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt <= '0;
    end else if ((state == S_WAIT_ACK) && ack_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign o_frame_count = frame_cnt;
`else
  assign o_frame_count = '0;
`endif

endmodule

// File: tb/tb_spi_send_sequencer.sv
// Directed bench for spi_send_sequencer: scoreboarded frame data, handshake timing and error recovery.
module tb_spi_send_sequencer;

  localparam int unsigned TMO = 128;
  localparam int unsigned GAP = 8;

  logic        c_clk_100m = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wr_valid = 1'b0;
  logic        o_wr_ready;
  logic [31:0] i_wr_data = '0;
  logic        o_SPI_Send_Sync;
  logic [31:0] o_SPI_Send_Data;
  logic        i_SPI_Send_Over_ack = 1'b0;
  logic        i_clr_err = 1'b0;
  logic        o_busy;
  logic [3:0]  o_fifo_level;
  logic        o_timeout_pulse;
  logic        o_err;
  logic [15:0] o_frame_count;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic        exp_sync = 1'b0;
  int          fc_exp = 0;

  spi_send_sequencer #(
    .DEPTH(8),
    .TIMEOUT_CYCLES(TMO),
    .GAP_CYCLES(GAP)
  ) dut (
    .c_clk_100m(c_clk_100m),
    .i_rst_n(i_rst_n),
    .i_wr_valid(i_wr_valid),
    .o_wr_ready(o_wr_ready),
    .i_wr_data(i_wr_data),
    .o_SPI_Send_Sync(o_SPI_Send_Sync),
    .o_SPI_Send_Data(o_SPI_Send_Data),
    .i_SPI_Send_Over_ack(i_SPI_Send_Over_ack),
    .i_clr_err(i_clr_err),
    .o_busy(o_busy),
    .o_fifo_level(o_fifo_level),
    .o_timeout_pulse(o_timeout_pulse),
    .o_err(o_err),
    .o_frame_count(o_frame_count)
  );

  always #5 c_clk_100m = ~c_clk_100m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fc_model();
`ifdef SPI_SEQ_STATS_EN
    return fc_exp[15:0];
`else
    return 16'h0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge c_clk_100m);
  endtask

  task automatic wr(input logic [31:0] d, input logic accept);
    i_wr_valid = 1'b1;
    i_wr_data  = d;
    chk("wr_ready", o_wr_ready, accept);
    if (accept) exp_q.push_back(d);
    @(negedge c_clk_100m);
    i_wr_valid = 1'b0;
  endtask

  task automatic master_ack();
    i_SPI_Send_Over_ack = ~i_SPI_Send_Over_ack;
    fc_exp++;
  endtask

  task automatic wait_toggle(input string tag, input int budget);
    int   n;
    logic want;
    n = 0;
    want = ~exp_sync;
    while (o_SPI_Send_Sync === exp_sync && n < budget) begin
      @(negedge c_clk_100m);
      n++;
    end
    chk(tag, o_SPI_Send_Sync, want);
    exp_sync = want;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < budget) begin
      @(negedge c_clk_100m);
      n++;
    end
    chk(tag, o_busy, 1'b0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ready"}, o_wr_ready, 1'b1);
    chk({p, "_sync"}, o_SPI_Send_Sync, 1'b0);
    chk({p, "_data"}, o_SPI_Send_Data, 32'h0);
    chk({p, "_busy"}, o_busy, 1'b0);
    chk({p, "_level"}, o_fifo_level, 4'd0);
    chk({p, "_tmo"}, o_timeout_pulse, 1'b0);
    chk({p, "_err"}, o_err, 1'b0);
    chk({p, "_fc"}, o_frame_count, 16'h0);
  endtask

  // Frame monitor: every Sync toggle pops the scoreboard and checks spacing to the previous launch.
  logic mon_prev = 1'b0;
  int   mon_cyc = 0;
  int   last_cyc = 0;
  bit   have_last = 1'b0;

  always @(negedge c_clk_100m) begin
    mon_cyc++;
    if (!i_rst_n) begin
      have_last = 1'b0;
    end else if (o_SPI_Send_Sync !== mon_prev) begin
      chk("frame_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("frame_data", o_SPI_Send_Data, exp_q.pop_front());
      if (have_last) chk("frame_gap", (mon_cyc - last_cyc) >= int'(GAP), 1'b1);
      last_cyc  = mon_cyc;
      have_last = 1'b1;
    end
    mon_prev = o_SPI_Send_Sync;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    chk_reset("rst");
    i_rst_n = 1'b1;
    tick(1);

    // Single word: Sync toggles on the third edge after the write.
    wr(32'h00A5_C3F1, 1'b1);
    chk("t1_level_wr", o_fifo_level, 4'd1);
    chk("t1_sync_e1", o_SPI_Send_Sync, 1'b0);
    tick(1);
    chk("t1_sync_e2", o_SPI_Send_Sync, 1'b0);
    chk("t1_data_pop", o_SPI_Send_Data, 32'h00A5_C3F1);
    chk("t1_level_pop", o_fifo_level, 4'd0);
    chk("t1_busy", o_busy, 1'b1);
    tick(1);
    chk("t1_sync_e3", o_SPI_Send_Sync, 1'b1);
    exp_sync = 1'b1;
    tick(59);
    chk("t1_data_hold", o_SPI_Send_Data, 32'h00A5_C3F1);
    chk("t1_err", o_err, 1'b0);
    master_ack();
    tick(int'(GAP) + 2);
    chk("t1_busy_gap", o_busy, 1'b1);
    tick(1);
    chk("t1_busy_fall", o_busy, 1'b0);
    chk("t1_data_after", o_SPI_Send_Data, 32'h00A5_C3F1);
    chk("t1_fc", o_frame_count, fc_model());

    // Fill behind a stalled frame, then drain in order.
    wr(32'hC0DE_0000, 1'b1);
    wait_toggle("t2_w0_launch", 20);
    for (int i = 1; i <= 8; i++) wr(32'hC0DE_0000 + i, 1'b1);
    chk("t2_level_full", o_fifo_level, 4'd8);
    chk("t2_ready_full", o_wr_ready, 1'b0);
    wr(32'hDEAD_BEEF, 1'b0);
    chk("t2_level_ignored", o_fifo_level, 4'd8);
    for (int i = 0; i <= 8; i++) begin
      master_ack();
      if (i < 8) begin
        wait_toggle("t2_drain_launch", 40);
        tick(3);
      end
    end
    wait_idle("t2_idle", 40);
    chk("t2_level_empty", o_fifo_level, 4'd0);
    chk("t2_fc", o_frame_count, fc_model());

    // Timeout, late ack, clear, resume with the next queued word.
    wr(32'h7100_0000, 1'b1);
    wr(32'h7100_0001, 1'b1);
    wait_toggle("t3_launch", 20);
    tick(int'(TMO) - 1);
    chk("t3_pulse_early", o_timeout_pulse, 1'b0);
    chk("t3_err_early", o_err, 1'b0);
    tick(1);
    chk("t3_pulse", o_timeout_pulse, 1'b1);
    chk("t3_err_set", o_err, 1'b1);
    tick(1);
    chk("t3_pulse_once", o_timeout_pulse, 1'b0);
    chk("t3_err_sticky", o_err, 1'b1);
    tick(20);
    chk("t3_no_launch", o_SPI_Send_Sync, exp_sync);
    chk("t3_level_err", o_fifo_level, 4'd1);
    chk("t3_busy_err", o_busy, 1'b1);
    i_SPI_Send_Over_ack = ~i_SPI_Send_Over_ack;
    tick(5);
    chk("t3_err_late_ack", o_err, 1'b1);
    chk("t3_fc_late_ack", o_frame_count, fc_model());
    i_clr_err = 1'b1;
    tick(1);
    i_clr_err = 1'b0;
    chk("t3_err_clr", o_err, 1'b0);
    wait_toggle("t3_resume", 30);
    tick(20);
    chk("t3_no_spurious", o_busy, 1'b1);
    chk("t3_fc_no_spurious", o_frame_count, fc_model());
    master_ack();
    wait_idle("t3_idle", 40);
    chk("t3_fc", o_frame_count, fc_model());

    // Completion lands on the last counted cycle: no timeout.
    wr(32'h4C00_00C0, 1'b1);
    wait_toggle("t4_launch", 20);
    tick(int'(TMO) - 3);
    master_ack();
    tick(3);
    chk("t4_no_pulse", o_timeout_pulse, 1'b0);
    chk("t4_no_err", o_err, 1'b0);
    wait_idle("t4_idle", 40);
    chk("t4_err_after", o_err, 1'b0);
    chk("t4_fc", o_frame_count, fc_model());

    // Write on the same edge as the IDLE pop.
    wr(32'h5F00_0000, 1'b1);
    wait_toggle("t5_launch_f", 20);
    wr(32'h5F00_0001, 1'b1);
    master_ack();
    tick(int'(GAP) + 3);
    chk("t5_level_idle", o_fifo_level, 4'd1);
    wr(32'h5F00_0002, 1'b1);
    chk("t5_level_swap", o_fifo_level, 4'd1);
    chk("t5_data_p0", o_SPI_Send_Data, 32'h5F00_0001);
    wait_toggle("t5_launch_p0", 20);
    master_ack();
    wait_toggle("t5_launch_p1", 40);
    chk("t5_data_p1", o_SPI_Send_Data, 32'h5F00_0002);
    master_ack();
    wait_idle("t5_idle", 40);
    chk("t5_fc", o_frame_count, fc_model());

    // Reset in WAIT_ACK with a word still queued.
    wr(32'h6E00_0000, 1'b1);
    wr(32'h6E00_0001, 1'b1);
    wait_toggle("t6_launch", 20);
    tick(5);
    i_rst_n = 1'b0;
    #1;
    chk_reset("t6_rst");
    exp_q.delete();
    exp_sync = 1'b0;
    fc_exp = 0;
    i_SPI_Send_Over_ack = 1'b0;
    tick(2);
    i_rst_n = 1'b1;
    tick(1);
    chk("t6_level_after", o_fifo_level, 4'd0);
    wr(32'h6E00_00FF, 1'b1);
    tick(1);
    chk("t6_sync_e2", o_SPI_Send_Sync, 1'b0);
    tick(1);
    chk("t6_first_sync", o_SPI_Send_Sync, 1'b1);
    exp_sync = 1'b1;
    chk("t6_data", o_SPI_Send_Data, 32'h6E00_00FF);
    master_ack();
    wait_idle("t6_idle", 40);
    chk("t6_fc", o_frame_count, fc_model());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
